// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared full-adder cell functions and width limit
// Contents: FA_MAX_WIDTH, fa_sum(a,b,c), fa_carry(a,b,c)
package full_adder_pkg;
    localparam int FA_MAX_WIDTH = 64;
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction
    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: one combinational full-adder cell
// Ports: a, b (operand bits), ci (carry in), sum (sum bit), co (carry out)
module full_adder_bit
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);
    assign sum = fa_sum(a, b, ci);
    assign co  = fa_carry(a, b, ci);
endmodule

// File: rtl/full_adder_function.sv
// full_adder_function: WIDTH-bit ripple-carry adder with registered copies
// Ports: clk, rst (sync, active-high), x, y (addends), cin (carry in),
//        s, cout (combinational sum/carry), s_q, cout_q (registered, 1-cycle lag)
// Option: FULLADD_OVERFLOW_EN adds ovf (signed overflow) and ovf_q (registered)
module full_adder_function
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             cout,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q
`ifdef FULLADD_OVERFLOW_EN
    ,
    output logic             ovf,
    output logic             ovf_q
`endif
);
    logic [WIDTH:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a   (x[i]),
            .b   (y[i]),
            .ci  (c[i]),
            .sum (s[i]),
            .co  (c[i+1])
        );
    end
    assign cout = c[WIDTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s;
            cout_q <= cout;
        end
    end
`ifdef FULLADD_OVERFLOW_EN
    // Signed overflow: carry into the sign bit differs from carry out of it
    assign ovf = c[WIDTH] ^ c[WIDTH-1];
    always_ff @(posedge clk) begin
        ovf_q <= rst ? 1'b0 : ovf;
    end
`endif
endmodule

// File: tb/tb_full_adder_function.sv
// tb_full_adder_function: scoreboard bench for full_adder_function at WIDTH 1, 8, 32
module tb_full_adder_function;
    typedef struct {
        logic        r;
        logic        x1, y1, c1;
        logic [1:0]  e1;
        logic        o1;
        logic [7:0]  x8, y8;
        logic        c8;
        logic [8:0]  e8;
        logic        o8;
        logic [31:0] x32, y32;
        logic        c32;
        logic [32:0] e32;
        logic        o32;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x1 = 1'b0, y1 = 1'b0, c1 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0;
    logic c8 = 1'b0;
    logic [31:0] x32 = '0, y32 = '0;
    logic c32 = 1'b0;
    logic s1, co1, sq1, coq1;
    logic [7:0] s8, sq8;
    logic co8, coq8;
    logic [31:0] s32, sq32;
    logic co32, coq32;
`ifdef FULLADD_OVERFLOW_EN
    logic ov1, ovq1, ov8, ovq8, ov32, ovq32;
`endif

    always #20 clk = ~clk;

    full_adder_function #(.WIDTH(1)) d1 (
        .clk(clk), .rst(rst), .x(x1), .y(y1), .cin(c1),
        .cout(co1), .s(s1), .s_q(sq1), .cout_q(coq1)
`ifdef FULLADD_OVERFLOW_EN
        , .ovf(ov1), .ovf_q(ovq1)
`endif
    );
    full_adder_function #(.WIDTH(8)) d8 (
        .clk(clk), .rst(rst), .x(x8), .y(y8), .cin(c8),
        .cout(co8), .s(s8), .s_q(sq8), .cout_q(coq8)
`ifdef FULLADD_OVERFLOW_EN
        , .ovf(ov8), .ovf_q(ovq8)
`endif
    );
    full_adder_function #(.WIDTH(32)) d32 (
        .clk(clk), .rst(rst), .x(x32), .y(y32), .cin(c32),
        .cout(co32), .s(s32), .s_q(sq32), .cout_q(coq32)
`ifdef FULLADD_OVERFLOW_EN
        , .ovf(ov32), .ovf_q(ovq32)
`endif
    );

    item_t q[$];
    int total = 0;
    int bad = 0;
    item_t last;
    bit have_last = 1'b0;

    task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk_comb(input item_t it);
        cmp("comb_w1", 64'({co1, s1}), 64'(it.e1));
        cmp("comb_w8", 64'({co8, s8}), 64'(it.e8));
        cmp("comb_w32", 64'({co32, s32}), 64'(it.e32));
`ifdef FULLADD_OVERFLOW_EN
        cmp("ovf_w1", 64'(ov1), 64'(it.o1));
        cmp("ovf_w8", 64'(ov8), 64'(it.o8));
        cmp("ovf_w32", 64'(ov32), 64'(it.o32));
`endif
    endtask

    task automatic chk_reg(input string n, input item_t it);
        cmp({n, "_w1"}, 64'({coq1, sq1}), it.r ? 64'd0 : 64'(it.e1));
        cmp({n, "_w8"}, 64'({coq8, sq8}), it.r ? 64'd0 : 64'(it.e8));
        cmp({n, "_w32"}, 64'({coq32, sq32}), it.r ? 64'd0 : 64'(it.e32));
`ifdef FULLADD_OVERFLOW_EN
        cmp({n, "_ovf_w1"}, 64'(ovq1), it.r ? 64'd0 : 64'(it.o1));
        cmp({n, "_ovf_w8"}, 64'(ovq8), it.r ? 64'd0 : 64'(it.o8));
        cmp({n, "_ovf_w32"}, 64'(ovq32), it.r ? 64'd0 : 64'(it.o32));
`endif
    endtask

    function automatic item_t mk(input logic r, input logic a1, input logic b1, input logic ci1,
                                 input logic [7:0] a8, input logic [7:0] b8, input logic ci8,
                                 input logic [31:0] a32, input logic [31:0] b32, input logic ci32);
        item_t it;
        it.r = r;
        it.x1 = a1; it.y1 = b1; it.c1 = ci1;
        it.x8 = a8; it.y8 = b8; it.c8 = ci8;
        it.x32 = a32; it.y32 = b32; it.c32 = ci32;
        it.e1 = 2'(a1) + 2'(b1) + 2'(ci1);
        it.e8 = 9'(a8) + 9'(b8) + 9'(ci8);
        it.e32 = 33'(a32) + 33'(b32) + 33'(ci32);
        it.o1 = (a1 == b1) && (it.e1[0] != a1);
        it.o8 = (a8[7] == b8[7]) && (it.e8[7] != a8[7]);
        it.o32 = (a32[31] == b32[31]) && (it.e32[31] != a32[31]);
        return it;
    endfunction

    function automatic item_t dir1(input logic r, input logic a, input logic b, input logic ci,
                                   input logic [1:0] e, input logic o);
        item_t it;
        it = mk(r, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 32'h0, 32'h0, 1'b0);
        it.x1 = a; it.y1 = b; it.c1 = ci; it.e1 = e; it.o1 = o;
        return it;
    endfunction

    function automatic item_t dir8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                                   input logic [8:0] e, input logic o);
        item_t it;
        it = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 32'h0, 32'h0, 1'b0);
        it.x8 = a; it.y8 = b; it.c8 = ci; it.e8 = e; it.o8 = o;
        return it;
    endfunction

    task automatic drive(input item_t it);
        rst = it.r;
        x1 = it.x1; y1 = it.y1; c1 = it.c1;
        x8 = it.x8; y8 = it.y8; c8 = it.c8;
        x32 = it.x32; y32 = it.y32; c32 = it.c32;
        q.push_back(it);
        @(negedge clk);
    endtask

    initial begin : mon_edge
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                it = q.pop_front();
                chk_comb(it);
                chk_reg("reg", it);
                last = it;
                have_last = 1'b1;
            end
        end
    end

    initial begin : mon_hold
        forever begin
            @(negedge clk);
            #1;
            if (have_last) chk_reg("hold", last);
        end
    end

    initial begin : stim
        drive(dir1(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1));
        drive(dir1(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1));
        drive(dir1(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1));
        drive(dir1(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        drive(dir1(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0));
        drive(dir1(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0));
        drive(dir1(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1));
        drive(dir1(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1));
        drive(dir1(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0));
        drive(dir1(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0));
        drive(dir1(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0));
        drive(dir8(8'hFF, 8'h00, 1'b1, 9'h100, 1'b0));
        drive(dir8(8'h5A, 8'h33, 1'b0, 9'h08D, 1'b1));
        drive(dir8(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1));
        drive(dir8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0));
        drive(dir8(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0));
        drive(dir8(8'h00, 8'h00, 1'b0, 9'h000, 1'b0));
        drive(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1));
        drive(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 8'h80, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1));
        drive(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 8'h77, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0));
        drive(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 8'h77, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0));
        for (int i = 0; i < 1000; i++) begin
            drive(mk(1'($urandom_range(0, 49) == 0),
                     1'($urandom), 1'($urandom), 1'($urandom),
                     8'($urandom), 8'($urandom), 1'($urandom),
                     32'($urandom), 32'($urandom), 1'($urandom)));
        end
        repeat (3) @(negedge clk);
        cmp("drain", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
